// File: rtl/shift_reg_universal.sv
// ----------------------------------------------------------------------------
// shift_reg_universal
//
// Purpose:
//   SHIFTERLEN-deep line of BITWIDTH-bit stages with per-stage valid bits and a
//   registered occupancy count. Serves as a generic staging / delay line
//   (age-ordered tags, issue history) in the out-of-order pipeline.
//   Modes: 0 HOLD, 1 SHL, 2 SHR, 3 ROTL, 4 ROTR, 5 LOAD, 6 CLEAR, 7 HOLD.
//   "Left" means stage i-1 moves into stage i, so stage 0 is the entry point.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-low reset (clears data, valid, count)
//   mode      in   operation select (see above)
//   inL       in   serial data entering stage 0 on SHL
//   inLValid  in   valid bit accompanying inL
//   inR       in   serial data entering stage SHIFTERLEN-1 on SHR
//   inRValid  in   valid bit accompanying inR
//   parIn     in   parallel load data, parIn[x] goes to stage x
//   parValid  in   parallel load valid mask
//   out       out  stage contents, out[x] is stage x
//   valid     out  per-stage valid bits
//   outL      out  out[SHIFTERLEN-1], the stage leaving on SHL
//   outR      out  out[0], the stage leaving on SHR
//   count     out  registered number of set valid bits
// ----------------------------------------------------------------------------
module shift_reg_universal #(
   parameter int BITWIDTH   = 1,
   parameter int SHIFTERLEN = 10
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [2:0]                           mode,
   input  logic [BITWIDTH-1:0]                  inL,
   input  logic                                 inLValid,
   input  logic [BITWIDTH-1:0]                  inR,
   input  logic                                 inRValid,
   input  logic [BITWIDTH-1:0]                  parIn [SHIFTERLEN-1:0],
   input  logic [SHIFTERLEN-1:0]                parValid,
   output logic [BITWIDTH-1:0]                  out [SHIFTERLEN-1:0],
   output logic [SHIFTERLEN-1:0]                valid,
   output logic [BITWIDTH-1:0]                  outL,
   output logic [BITWIDTH-1:0]                  outR,
   output logic [$clog2(SHIFTERLEN+1)-1:0]      count
);

   localparam int CW = $clog2(SHIFTERLEN + 1);

   localparam logic [2:0] MODE_HOLD  = 3'd0;
   localparam logic [2:0] MODE_SHL   = 3'd1;
   localparam logic [2:0] MODE_SHR   = 3'd2;
   localparam logic [2:0] MODE_ROTL  = 3'd3;
   localparam logic [2:0] MODE_ROTR  = 3'd4;
   localparam logic [2:0] MODE_LOAD  = 3'd5;
   localparam logic [2:0] MODE_CLEAR = 3'd6;
   localparam logic [2:0] MODE_HOLD7 = 3'd7;

   logic [BITWIDTH-1:0]   out_q   [SHIFTERLEN-1:0];
   logic [BITWIDTH-1:0]   out_d   [SHIFTERLEN-1:0];
   logic [SHIFTERLEN-1:0] valid_q;
   logic [SHIFTERLEN-1:0] valid_d;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_d;
   logic [CW-1:0]         load_pop;

   // Per-stage next-state. Each stage sees its lower neighbour (SHL/ROTL
   // source) and upper neighbour (SHR/ROTR source); the end stages swap in
   // the serial input or the wrap-around stage instead. With SHIFTERLEN==1
   // the rotate sources are the stage itself, so ROTL/ROTR degenerate to HOLD.
   genvar gi;
   generate
      for (gi = 0; gi < SHIFTERLEN; gi++) begin : g_stage
         logic [BITWIDTH-1:0] shl_data, rotl_data, shr_data, rotr_data;
         logic                shl_vld,  rotl_vld,  shr_vld,  rotr_vld;
         logic [BITWIDTH-1:0] stage_d;
         logic                stage_vld_d;

         if (gi == 0) begin : g_lo_entry
            assign shl_data  = inL;
            assign shl_vld   = inLValid;
            assign rotl_data = out_q[SHIFTERLEN-1];
            assign rotl_vld  = valid_q[SHIFTERLEN-1];
         end else begin : g_lo_chain
            assign shl_data  = out_q[gi-1];
            assign shl_vld   = valid_q[gi-1];
            assign rotl_data = out_q[gi-1];
            assign rotl_vld  = valid_q[gi-1];
         end

         if (gi == SHIFTERLEN-1) begin : g_hi_entry
            assign shr_data  = inR;
            assign shr_vld   = inRValid;
            assign rotr_data = out_q[0];
            assign rotr_vld  = valid_q[0];
         end else begin : g_hi_chain
            assign shr_data  = out_q[gi+1];
            assign shr_vld   = valid_q[gi+1];
            assign rotr_data = out_q[gi+1];
            assign rotr_vld  = valid_q[gi+1];
         end

         always_comb begin
            stage_d     = out_q[gi];
            stage_vld_d = valid_q[gi];
            case (mode)
               MODE_SHL: begin
                  stage_d     = shl_data;
                  stage_vld_d = shl_vld;
               end
               MODE_SHR: begin
                  stage_d     = shr_data;
                  stage_vld_d = shr_vld;
               end
               MODE_ROTL: begin
                  stage_d     = rotl_data;
                  stage_vld_d = rotl_vld;
               end
               MODE_ROTR: begin
                  stage_d     = rotr_data;
                  stage_vld_d = rotr_vld;
               end
               MODE_LOAD: begin
                  stage_d     = parIn[gi];
                  stage_vld_d = parValid[gi];
               end
               MODE_CLEAR: begin
                  stage_d     = '0;
                  stage_vld_d = 1'b0;
               end
               MODE_HOLD, MODE_HOLD7: ;
               default: ;
            endcase
         end

         assign out_d[gi]   = stage_d;
         assign valid_d[gi] = stage_vld_d;
      end
   endgenerate

   // Popcount is only needed when a whole new mask arrives on LOAD.
   always_comb begin
      load_pop = '0;
      for (int i = 0; i < SHIFTERLEN; i++) begin
         load_pop = load_pop + CW'(parValid[i]);
      end
   end

   // Incremental count: one entry enters and one leaves on a shift. The
   // intermediate may wrap, but the final value always lies in 0..SHIFTERLEN.
   always_comb begin
      count_d = count_q;
      case (mode)
         MODE_SHL:   count_d = count_q + CW'(inLValid) - CW'(valid_q[SHIFTERLEN-1]);
         MODE_SHR:   count_d = count_q + CW'(inRValid) - CW'(valid_q[0]);
         MODE_LOAD:  count_d = load_pop;
         MODE_CLEAR: count_d = '0;
         default:    count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < SHIFTERLEN; i++) begin
            out_q[i] <= '0;
         end
         valid_q <= '0;
         count_q <= '0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;
   assign count = count_q;
   assign outL  = out_q[SHIFTERLEN-1];
   assign outR  = out_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
module tb_shift_reg_universal;

   localparam logic [2:0] HOLD  = 3'd0;
   localparam logic [2:0] SHL   = 3'd1;
   localparam logic [2:0] SHR   = 3'd2;
   localparam logic [2:0] ROTL  = 3'd3;
   localparam logic [2:0] ROTR  = 3'd4;
   localparam logic [2:0] LOAD  = 3'd5;
   localparam logic [2:0] CLEAR = 3'd6;
   localparam logic [2:0] HOLD7 = 3'd7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus for all three instances
   logic       reset;
   logic [2:0] mode;
   logic [7:0] inL, inR;
   logic       inLValid, inRValid;
   logic [7:0] par_all [10];
   logic [9:0] pv_all;

   logic [7:0] par4 [3:0];
   logic [7:0] par1 [0:0];
   logic [7:0] par10 [9:0];

   always_comb begin
      for (int i = 0; i < 4; i++) par4[i] = par_all[i];
      par1[0] = par_all[0];
      for (int i = 0; i < 10; i++) par10[i] = par_all[i];
   end

   logic [7:0] out4 [3:0];
   logic [3:0] valid4;
   logic [7:0] outL4, outR4;
   logic [2:0] count4;

   logic [7:0] out1 [0:0];
   logic [0:0] valid1;
   logic [7:0] outL1, outR1;
   logic [0:0] count1;

   logic [7:0] out10 [9:0];
   logic [9:0] valid10;
   logic [7:0] outL10, outR10;
   logic [3:0] count10;

   shift_reg_universal #(.BITWIDTH(8), .SHIFTERLEN(4)) u_dut4 (
      .clk(clk), .reset(reset), .mode(mode),
      .inL(inL), .inLValid(inLValid), .inR(inR), .inRValid(inRValid),
      .parIn(par4), .parValid(pv_all[3:0]),
      .out(out4), .valid(valid4), .outL(outL4), .outR(outR4), .count(count4)
   );

   shift_reg_universal #(.BITWIDTH(8), .SHIFTERLEN(1)) u_dut1 (
      .clk(clk), .reset(reset), .mode(mode),
      .inL(inL), .inLValid(inLValid), .inR(inR), .inRValid(inRValid),
      .parIn(par1), .parValid(pv_all[0:0]),
      .out(out1), .valid(valid1), .outL(outL1), .outR(outR1), .count(count1)
   );

   shift_reg_universal #(.BITWIDTH(8), .SHIFTERLEN(10)) u_dut10 (
      .clk(clk), .reset(reset), .mode(mode),
      .inL(inL), .inLValid(inLValid), .inR(inR), .inRValid(inRValid),
      .parIn(par10), .parValid(pv_all),
      .out(out10), .valid(valid10), .outL(outL10), .outR(outR10), .count(count10)
   );

   // Observed outputs gathered into a uniform shape (instance k: 0->L4, 1->L1, 2->L10)
   logic [7:0] obs_data  [3][10];
   logic       obs_valid [3][10];
   logic [3:0] obs_count [3];
   logic [7:0] obs_outL  [3];
   logic [7:0] obs_outR  [3];

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 10; i++) begin
            obs_data[k][i]  = '0;
            obs_valid[k][i] = 1'b0;
         end
      end
      for (int i = 0; i < 4; i++) begin
         obs_data[0][i]  = out4[i];
         obs_valid[0][i] = valid4[i];
      end
      obs_data[1][0]  = out1[0];
      obs_valid[1][0] = valid1[0];
      for (int i = 0; i < 10; i++) begin
         obs_data[2][i]  = out10[i];
         obs_valid[2][i] = valid10[i];
      end
      obs_count[0] = {1'b0, count4};
      obs_count[1] = {3'b000, count1};
      obs_count[2] = count10;
      obs_outL[0] = outL4;  obs_outR[0] = outR4;
      obs_outL[1] = outL1;  obs_outR[1] = outR1;
      obs_outL[2] = outL10; obs_outR[2] = outR10;
   end

   // Reference model
   logic [7:0] m_data  [3][10];
   logic       m_valid [3][10];

   function automatic int len_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 10;
      endcase
   endfunction

   function automatic int m_pop(input int k);
      int c = 0;
      for (int i = 0; i < len_of(k); i++) c += int'(m_valid[k][i]);
      return c;
   endfunction

   function automatic int obs_pop(input int k);
      int c = 0;
      for (int i = 0; i < len_of(k); i++) c += int'(obs_valid[k][i]);
      return c;
   endfunction

   task automatic model_step();
      logic [7:0] od [10];
      logic       ov [10];
      for (int k = 0; k < 3; k++) begin
         int n = len_of(k);
         for (int i = 0; i < 10; i++) begin
            od[i] = m_data[k][i];
            ov[i] = m_valid[k][i];
         end
         for (int i = 0; i < n; i++) begin
            if (!reset || mode == CLEAR) begin
               m_data[k][i] = '0; m_valid[k][i] = 1'b0;
            end else if (mode == SHL) begin
               m_data[k][i]  = (i == 0) ? inL      : od[i-1];
               m_valid[k][i] = (i == 0) ? inLValid : ov[i-1];
            end else if (mode == SHR) begin
               m_data[k][i]  = (i == n-1) ? inR      : od[i+1];
               m_valid[k][i] = (i == n-1) ? inRValid : ov[i+1];
            end else if (mode == ROTL) begin
               m_data[k][i]  = od[(i + n - 1) % n];
               m_valid[k][i] = ov[(i + n - 1) % n];
            end else if (mode == ROTR) begin
               m_data[k][i]  = od[(i + 1) % n];
               m_valid[k][i] = ov[(i + 1) % n];
            end else if (mode == LOAD) begin
               m_data[k][i]  = par_all[i];
               m_valid[k][i] = pv_all[i];
            end
         end
      end
   endtask

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input bit ok, input string got, input string exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %s, expected %s", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic check_model(input int k, input int cyc);
      bit ok = 1'b1;
      int n = len_of(k);
      for (int i = 0; i < n; i++) begin
         if (obs_data[k][i] !== m_data[k][i] || obs_valid[k][i] !== m_valid[k][i]) ok = 1'b0;
      end
      if (obs_count[k] !== 4'(m_pop(k)))       ok = 1'b0;
      if (obs_count[k] !== 4'(obs_pop(k)))     ok = 1'b0;
      if (obs_outL[k] !== m_data[k][n-1])      ok = 1'b0;
      if (obs_outR[k] !== m_data[k][0])        ok = 1'b0;
      check($sformatf("rand_len%0d_cyc%0d", n, cyc), ok,
            $sformatf("count=%0d popvalid=%0d outL=%h outR=%h", obs_count[k], obs_pop(k), obs_outL[k], obs_outR[k]),
            $sformatf("count=%0d outL=%h outR=%h (plus matching stages)", m_pop(k), m_data[k][n-1], m_data[k][0]));
   endtask

   // Directed vectors for the 4 x 8-bit instance; state carries between rows
   typedef struct {
      logic [2:0]      mode;
      logic [7:0]      inl;
      logic            inlv;
      logic [7:0]      inr;
      logic            inrv;
      logic [3:0][7:0] par;
      logic [3:0]      pv;
      logic [3:0][7:0] eout;
      logic [3:0]      ev;
      logic [2:0]      ec;
   } vec_t;

   vec_t vecs [24];

   function automatic vec_t mk(input logic [2:0] m, input logic [7:0] il, input logic ilv,
                               input logic [7:0] ir, input logic irv, input logic [3:0][7:0] p,
                               input logic [3:0] pv, input logic [3:0][7:0] eo,
                               input logic [3:0] ev, input logic [2:0] ec);
      vec_t v;
      v.mode = m; v.inl = il; v.inlv = ilv; v.inr = ir; v.inrv = irv;
      v.par = p; v.pv = pv; v.eout = eo; v.ev = ev; v.ec = ec;
      return v;
   endfunction

   initial begin
      logic [3:0][7:0] got;
      logic [7:0]      el, er;
      bit              ok;

      vecs[0]  = mk(SHL,  8'h11,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h00,8'h00,8'h00,8'h11},4'b0001,3'd1);
      vecs[1]  = mk(SHL,  8'h22,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h00,8'h00,8'h11,8'h22},4'b0011,3'd2);
      vecs[2]  = mk(SHL,  8'h33,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h00,8'h11,8'h22,8'h33},4'b0111,3'd3);
      vecs[3]  = mk(SHL,  8'h44,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h11,8'h22,8'h33,8'h44},4'b1111,3'd4);
      vecs[4]  = mk(SHL,  8'h55,0, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h22,8'h33,8'h44,8'h55},4'b1110,3'd3);
      vecs[5]  = mk(LOAD, 8'h77,1, 8'hEE,1, {8'h11,8'h22,8'h33,8'h44},4'hF, {8'h11,8'h22,8'h33,8'h44},4'b1111,3'd4);
      vecs[6]  = mk(SHR,  8'hEE,1, 8'h99,0, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h99,8'h11,8'h22,8'h33},4'b0111,3'd3);
      vecs[7]  = mk(SHR,  8'hEE,1, 8'h98,0, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h98,8'h99,8'h11,8'h22},4'b0011,3'd2);
      vecs[8]  = mk(SHR,  8'hEE,1, 8'h97,0, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h97,8'h98,8'h99,8'h11},4'b0001,3'd1);
      vecs[9]  = mk(SHR,  8'hEE,1, 8'h96,0, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h96,8'h97,8'h98,8'h99},4'b0000,3'd0);
      vecs[10] = mk(SHR,  8'hEE,1, 8'h5A,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h5A,8'h96,8'h97,8'h98},4'b1000,3'd1);
      vecs[11] = mk(LOAD, 8'hEE,1, 8'hEE,1, {8'h0A,8'h0B,8'h0C,8'h0D},4'b0101, {8'h0A,8'h0B,8'h0C,8'h0D},4'b0101,3'd2);
      vecs[12] = mk(ROTL, 8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0B,8'h0C,8'h0D,8'h0A},4'b1010,3'd2);
      vecs[13] = mk(ROTR, 8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0A,8'h0B,8'h0C,8'h0D},4'b0101,3'd2);
      vecs[14] = mk(ROTR, 8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0D,8'h0A,8'h0B,8'h0C},4'b1010,3'd2);
      vecs[15] = mk(HOLD, 8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0D,8'h0A,8'h0B,8'h0C},4'b1010,3'd2);
      vecs[16] = mk(HOLD7,8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0D,8'h0A,8'h0B,8'h0C},4'b1010,3'd2);
      vecs[17] = mk(CLEAR,8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h00,8'h00,8'h00,8'h00},4'b0000,3'd0);
      vecs[18] = mk(LOAD, 8'hEE,1, 8'hEE,1, {8'h12,8'h34,8'h56,8'h78},4'b0000, {8'h12,8'h34,8'h56,8'h78},4'b0000,3'd0);
      vecs[19] = mk(SHL,  8'hC3,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h34,8'h56,8'h78,8'hC3},4'b0001,3'd1);
      vecs[20] = mk(ROTL, 8'hEE,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h56,8'h78,8'hC3,8'h34},4'b0010,3'd1);
      vecs[21] = mk(LOAD, 8'hEE,1, 8'hEE,1, {8'hF0,8'h0F,8'hAA,8'h55},4'b1011, {8'hF0,8'h0F,8'hAA,8'h55},4'b1011,3'd3);
      vecs[22] = mk(SHL,  8'h01,1, 8'hEE,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h0F,8'hAA,8'h55,8'h01},4'b0111,3'd3);
      vecs[23] = mk(SHR,  8'hEE,1, 8'h02,1, {8'hDE,8'hAD,8'hBE,8'hEF},4'hF, {8'h02,8'h0F,8'hAA,8'h55},4'b1011,3'd3);

      // Reset from power-up
      reset = 1'b0; mode = LOAD; inL = 8'hFF; inLValid = 1'b1; inR = 8'hFF; inRValid = 1'b1;
      for (int i = 0; i < 10; i++) par_all[i] = 8'hFF;
      pv_all = '1;
      step(); step();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_init_len%0d", len_of(k)),
               obs_pop(k) == 0 && obs_count[k] == 4'd0 && obs_data[k][0] == 8'h00 && obs_outL[k] == 8'h00,
               $sformatf("count=%0d popvalid=%0d out0=%h outL=%h", obs_count[k], obs_pop(k), obs_data[k][0], obs_outL[k]),
               "count=0 popvalid=0 out0=00 outL=00");
      end

      // Table-driven vectors on the 4-stage instance
      reset = 1'b1;
      for (int v = 0; v < 24; v++) begin
         mode = vecs[v].mode; inL = vecs[v].inl; inLValid = vecs[v].inlv;
         inR = vecs[v].inr; inRValid = vecs[v].inrv;
         for (int i = 0; i < 4; i++) par_all[i] = vecs[v].par[i];
         pv_all = {6'b0, vecs[v].pv};
         step();
         for (int i = 0; i < 4; i++) got[i] = out4[i];
         el = vecs[v].eout[3];
         er = vecs[v].eout[0];
         ok = (got == vecs[v].eout) && (valid4 == vecs[v].ev) && (count4 == vecs[v].ec) &&
              (outL4 == el) && (outR4 == er);
         $display("vec %0d mode=%0d out=%h valid=%b count=%0d outL=%h outR=%h", v, mode, got, valid4, count4, outL4, outR4);
         check($sformatf("vec%0d", v), ok,
               $sformatf("out=%h valid=%b count=%0d outL=%h outR=%h", got, valid4, count4, outL4, outR4),
               $sformatf("out=%h valid=%b count=%0d outL=%h outR=%h", vecs[v].eout, vecs[v].ev, vecs[v].ec, el, er));
      end

      // Reset overrides a LOAD presented in the same cycle
      mode = LOAD; pv_all = '1;
      for (int i = 0; i < 10; i++) par_all[i] = 8'hC5;
      step();
      reset = 1'b0;
      step();
      for (int i = 0; i < 4; i++) got[i] = out4[i];
      check("reset_over_load", got == 32'h0 && valid4 == 4'b0 && count4 == 3'd0 && count10 == 4'd0 && valid10 == 10'b0,
            $sformatf("out=%h valid=%b count=%0d count10=%0d", got, valid4, count4, count10),
            "out=00000000 valid=0000 count=0 count10=0");
      reset = 1'b1;

      // Single-stage corner cases
      mode = SHL; inL = 8'h3C; inLValid = 1'b1;
      step();
      check("len1_shl", out1[0] == 8'h3C && valid1 == 1'b1 && count1 == 1'b1 && outL1 == 8'h3C && outR1 == 8'h3C,
            $sformatf("out=%h valid=%b count=%0d outL=%h outR=%h", out1[0], valid1, count1, outL1, outR1),
            "out=3c valid=1 count=1 outL=3c outR=3c");
      mode = ROTL; step();
      mode = ROTR; step();
      check("len1_rot_hold", out1[0] == 8'h3C && valid1 == 1'b1 && count1 == 1'b1,
            $sformatf("out=%h valid=%b count=%0d", out1[0], valid1, count1), "out=3c valid=1 count=1");
      mode = SHR; inR = 8'h05; inRValid = 1'b0;
      step();
      check("len1_shr_invalid", out1[0] == 8'h05 && valid1 == 1'b0 && count1 == 1'b0,
            $sformatf("out=%h valid=%b count=%0d", out1[0], valid1, count1), "out=05 valid=0 count=0");
      mode = SHL; inL = 8'hA5; inLValid = 1'b1; step();
      mode = SHR; inR = 8'h5A; inRValid = 1'b1; step();
      check("len1_shr_replace", out1[0] == 8'h5A && valid1 == 1'b1 && count1 == 1'b1,
            $sformatf("out=%h valid=%b count=%0d", out1[0], valid1, count1), "out=5a valid=1 count=1");

      // Random regression on all three lengths against the model
      reset = 1'b0; step();
      for (int c = 0; c < 10000; c++) begin
         reset    = ($urandom_range(0, 199) != 0);
         mode     = 3'($urandom_range(0, 7));
         inL      = 8'($urandom);
         inR      = 8'($urandom);
         inLValid = 1'($urandom);
         inRValid = 1'($urandom);
         pv_all   = 10'($urandom);
         for (int i = 0; i < 10; i++) par_all[i] = 8'($urandom);
         step();
         for (int k = 0; k < 3; k++) check_model(k, c);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
